// File: rtl/avalon_sdram_arbiter.sv
// avalon_sdram_arbiter: round-robin two-master Avalon-MM arbiter in front of the SDRAM controller,
// with request locking under stall and an in-order owner FIFO that routes read data back.
module avalon_sdram_arbiter #(
    parameter int AW          = 24,
    parameter int DW          = 16,
    parameter int BYTE        = DW/8,
    parameter int MAX_PENDING = 8,
    localparam int PW         = $clog2(MAX_PENDING),
    localparam int CW         = $clog2(MAX_PENDING+1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_read,
    input  logic            m0_write,
    input  logic [AW-1:0]   m0_address,
    input  logic [DW-1:0]   m0_writedata,
    input  logic [BYTE-1:0] m0_byteenable,
    output logic            m0_waitrequest,
    output logic [DW-1:0]   m0_readdata,
    output logic            m0_readdatavalid,
    input  logic            m1_read,
    input  logic            m1_write,
    input  logic [AW-1:0]   m1_address,
    input  logic [DW-1:0]   m1_writedata,
    input  logic [BYTE-1:0] m1_byteenable,
    output logic            m1_waitrequest,
    output logic [DW-1:0]   m1_readdata,
    output logic            m1_readdatavalid,
    output logic            s_read,
    output logic            s_write,
    output logic [AW-1:0]   s_address,
    output logic [DW-1:0]   s_writedata,
    output logic [BYTE-1:0] s_byteenable,
    input  logic            s_waitrequest,
    input  logic [DW-1:0]   s_readdata,
    input  logic            s_readdatavalid,
    output logic [CW-1:0]   pending_cnt,
    output logic            err_orphan
);
    logic last_gnt_q, last_gnt_d, locked_q, locked_d, locked_id_q, locked_id_d, err_q, err_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MAX_PENDING-1:0] tag_q;
    logic tag_empty, tag_full, push, pop, elig0, elig1, sel, sel_vld, accept, stall;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            last_gnt_q  <= 1'b1;
            locked_q    <= 1'b0;
            locked_id_q <= 1'b0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            tag_q       <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            locked_q    <= locked_d;
            locked_id_q <= locked_id_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            if (push) tag_q[wr_ptr_q] <= sel;
            wr_ptr_q    <= wr_ptr_q + PW'(push);
            rd_ptr_q    <= rd_ptr_q + PW'(pop);
        end

    // A pop in this cycle frees a slot, so a waiting read may be pushed alongside it.
    always_comb begin
        tag_empty        = cnt_q == '0;
        pop              = s_readdatavalid & ~tag_empty;
        tag_full         = (cnt_q == CW'(MAX_PENDING)) & ~pop;
        elig0            = (m0_read | m0_write) & ~(m0_read & tag_full);
        elig1            = (m1_read | m1_write) & ~(m1_read & tag_full);
        sel_vld          = locked_q | elig0 | elig1;
        sel              = locked_q ? locked_id_q : (elig0 & elig1) ? ~last_gnt_q : elig1;
        s_read           = sel_vld & (sel ? m1_read : m0_read);
        s_write          = sel_vld & (sel ? m1_write : m0_write);
        s_address        = sel ? m1_address : m0_address;
        s_writedata      = sel ? m1_writedata : m0_writedata;
        s_byteenable     = sel ? m1_byteenable : m0_byteenable;
        accept           = (s_read | s_write) & ~s_waitrequest;
        stall            = (s_read | s_write) & s_waitrequest;
        m0_waitrequest   = ~(accept & ~sel);
        m1_waitrequest   = ~(accept & sel);
        m0_readdata      = s_readdata;
        m1_readdata      = s_readdata;
        m0_readdatavalid = pop & ~tag_q[rd_ptr_q];
        m1_readdatavalid = pop & tag_q[rd_ptr_q];
        pending_cnt      = cnt_q;
        err_orphan       = err_q;
    end

    always_comb begin
        push        = accept & s_read;
        last_gnt_d  = accept ? sel : last_gnt_q;
        locked_d    = accept ? 1'b0 : stall ? 1'b1 : locked_q;
        locked_id_d = stall ? sel : locked_id_q;
        cnt_d       = cnt_q + CW'(push) - CW'(pop);
        err_d       = err_q | (s_readdatavalid & tag_empty);
    end
endmodule
